// File: rtl/tuner_phy_ctrl_arb.sv
// Tuner controller arbiter: grants search/lock tune requests, drives the tuner code, returns sampled power.
// Optional: define TUNER_ARB_RR_EN for round-robin tie-break in INIT (default: lock has fixed priority).
module tuner_phy_ctrl_arb #(
   parameter int CODE_WIDTH     = 8,
   parameter int PWR_WIDTH      = 8,
   parameter int SYNC_CYCLES    = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_search_req,
   input  logic [CODE_WIDTH-1:0] i_search_code,
   output logic                  o_search_ack,
   input  logic                  i_lock_req,
   input  logic [CODE_WIDTH-1:0] i_lock_code,
   output logic                  o_lock_ack,
   output logic [PWR_WIDTH-1:0]  o_rsp_pwr,
   output logic                  o_rsp_err,
   output logic [CODE_WIDTH-1:0] o_tuner_code,
   output logic                  o_tuner_valid,
   output logic                  o_pwr_read,
   input  logic                  i_pwr_valid,
   input  logic [PWR_WIDTH-1:0]  i_pwr,
   output logic [1:0]            o_grant,
   output logic [1:0]            o_state
);

   typedef enum logic [1:0] {
      CH_NULL   = 2'd0,
      CH_SEARCH = 2'd1,
      CH_LOCK   = 2'd2
   } tuner_ctrl_ch_e;

   typedef enum logic [1:0] {
      ARB_CTRL_INIT   = 2'd0,
      ARB_CTRL_TUNE   = 2'd1,
      ARB_CTRL_SYNC   = 2'd2,
      ARB_CTRL_COMMIT = 2'd3
   } tuner_phy_ctrl_arb_state_e;

   // One counter spans settle and read window: read starts at READ_AT, times out at TMO_AT.
   localparam int CNT_W = $clog2(SYNC_CYCLES + TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] READ_AT = CNT_W'(SYNC_CYCLES);
   localparam logic [CNT_W-1:0] TMO_AT  = CNT_W'(SYNC_CYCLES + TIMEOUT_CYCLES - 1);

   tuner_phy_ctrl_arb_state_e state_q, state_d;
   tuner_ctrl_ch_e            grant_q, grant_d;
   tuner_ctrl_ch_e            win;
   logic [CODE_WIDTH-1:0]     code_q, code_d;
   logic                      tvalid_q, tvalid_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [PWR_WIDTH-1:0]      pwr_q, pwr_d;
   logic                      err_q, err_d;
   logic                      read_phase;
`ifdef TUNER_ARB_RR_EN
   tuner_ctrl_ch_e            last_q, last_d;
`endif

   always_comb begin
      win = CH_NULL;
      if (i_lock_req && i_search_req) begin
`ifdef TUNER_ARB_RR_EN
         win = (last_q == CH_LOCK) ? CH_SEARCH : CH_LOCK;
`else
         win = CH_LOCK;
`endif
      end else if (i_lock_req) begin
         win = CH_LOCK;
      end else if (i_search_req) begin
         win = CH_SEARCH;
      end
   end

   assign read_phase = (state_q == ARB_CTRL_SYNC) && (cnt_q >= READ_AT);

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      code_d   = code_q;
      tvalid_d = 1'b0;
      cnt_d    = cnt_q;
      pwr_d    = pwr_q;
      err_d    = err_q;
`ifdef TUNER_ARB_RR_EN
      last_d   = last_q;
`endif
      case (state_q)
         ARB_CTRL_INIT: begin
            if (win != CH_NULL) begin
               grant_d  = win;
               code_d   = (win == CH_LOCK) ? i_lock_code : i_search_code;
               tvalid_d = 1'b1;
               state_d  = ARB_CTRL_TUNE;
`ifdef TUNER_ARB_RR_EN
               last_d   = win;
`endif
            end
         end
         ARB_CTRL_TUNE: begin
            cnt_d   = '0;
            state_d = ARB_CTRL_SYNC;
         end
         ARB_CTRL_SYNC: begin
            if (!read_phase) begin
               cnt_d = cnt_q + 1'b1;
            end else if (i_pwr_valid) begin
               pwr_d   = i_pwr;
               err_d   = 1'b0;
               state_d = ARB_CTRL_COMMIT;
            end else if (cnt_q == TMO_AT) begin
               pwr_d   = '0;
               err_d   = 1'b1;
               state_d = ARB_CTRL_COMMIT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ARB_CTRL_COMMIT: begin
            grant_d = CH_NULL;
            cnt_d   = '0;
            state_d = ARB_CTRL_INIT;
         end
         default: state_d = ARB_CTRL_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ARB_CTRL_INIT;
         grant_q  <= CH_NULL;
         code_q   <= '0;
         tvalid_q <= 1'b0;
         cnt_q    <= '0;
         pwr_q    <= '0;
         err_q    <= 1'b0;
`ifdef TUNER_ARB_RR_EN
         last_q   <= CH_NULL;
`endif
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         code_q   <= code_d;
         tvalid_q <= tvalid_d;
         cnt_q    <= cnt_d;
         pwr_q    <= pwr_d;
         err_q    <= err_d;
`ifdef TUNER_ARB_RR_EN
         last_q   <= last_d;
`endif
      end
   end

   assign o_search_ack  = (state_q == ARB_CTRL_COMMIT) && (grant_q == CH_SEARCH);
   assign o_lock_ack    = (state_q == ARB_CTRL_COMMIT) && (grant_q == CH_LOCK);
   assign o_rsp_pwr     = pwr_q;
   assign o_rsp_err     = err_q;
   assign o_tuner_code  = code_q;
   assign o_tuner_valid = tvalid_q;
   assign o_pwr_read    = read_phase;
   assign o_grant       = grant_q;
   assign o_state       = state_q;

endmodule

// File: tb/tb_tuner_phy_ctrl_arb.sv
// Bench for tuner_phy_ctrl_arb: transaction-timeline model checked every cycle, directed and random stimulus.
module tb_tuner_phy_ctrl_arb;
   localparam int CW   = 8;
   localparam int PW   = 8;
   localparam int SYNC = 4;
   localparam int TMO  = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_search_req, i_lock_req, i_pwr_valid;
   logic [CW-1:0] i_search_code, i_lock_code;
   logic [PW-1:0] i_pwr;
   logic          o_search_ack, o_lock_ack, o_rsp_err, o_tuner_valid, o_pwr_read;
   logic [PW-1:0] o_rsp_pwr;
   logic [CW-1:0] o_tuner_code;
   logic [1:0]    o_grant, o_state;

   tuner_phy_ctrl_arb #(
      .CODE_WIDTH(CW), .PWR_WIDTH(PW), .SYNC_CYCLES(SYNC), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_search_req(i_search_req), .i_search_code(i_search_code), .o_search_ack(o_search_ack),
      .i_lock_req(i_lock_req), .i_lock_code(i_lock_code), .o_lock_ack(o_lock_ack),
      .o_rsp_pwr(o_rsp_pwr), .o_rsp_err(o_rsp_err),
      .o_tuner_code(o_tuner_code), .o_tuner_valid(o_tuner_valid),
      .o_pwr_read(o_pwr_read), .i_pwr_valid(i_pwr_valid), .i_pwr(i_pwr),
      .o_grant(o_grant), .o_state(o_state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Model: a transaction is the time elapsed since its grant edge; phases follow from that age.
   bit        m_busy;
   int        m_e, m_done, m_ch, m_last, m_tcode, m_pwr, m_err;
   bit        e_sack, e_lack;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic mreset();
      m_busy = 0; m_e = 0; m_done = -1; m_ch = 0; m_last = 0;
      m_tcode = 0; m_pwr = 0; m_err = 0;
   endtask

   task automatic mstep();
      int win;
      if (m_busy) begin
         if (m_e == m_done) m_busy = 0;
         else begin
            if (m_done < 0 && m_e >= SYNC + 2) begin
               if (i_pwr_valid) begin
                  m_pwr = int'(i_pwr); m_err = 0; m_done = m_e + 1;
               end else if (m_e == SYNC + 1 + TMO) begin
                  m_pwr = 0; m_err = 1; m_done = m_e + 1;
               end
            end
            m_e++;
         end
      end else begin
         win = 0;
         if (i_lock_req && i_search_req) begin
`ifdef TUNER_ARB_RR_EN
            win = (m_last == 2) ? 1 : 2;
`else
            win = 2;
`endif
         end else if (i_lock_req) win = 2;
         else if (i_search_req) win = 1;
         if (win != 0) begin
            m_busy = 1; m_e = 1; m_done = -1; m_ch = win; m_last = win;
            m_tcode = (win == 2) ? int'(i_lock_code) : int'(i_search_code);
         end
      end
   endtask

   task automatic compare();
      int es, eg, etv, erd, esa, ela;
      es = 0; eg = 0; etv = 0; erd = 0; esa = 0; ela = 0;
      if (m_busy) begin
         eg = m_ch;
         if (m_e == 1) begin es = 1; etv = 1; end
         else if (m_e == m_done) begin
            es = 3; esa = (m_ch == 1) ? 1 : 0; ela = (m_ch == 2) ? 1 : 0;
         end else begin
            es = 2; erd = (m_e >= SYNC + 2) ? 1 : 0;
         end
      end
      e_sack = (esa != 0); e_lack = (ela != 0);
      chk("state", int'(o_state), es);
      chk("grant", int'(o_grant), eg);
      chk("tuner_code", int'(o_tuner_code), m_tcode);
      chk("tuner_valid", int'(o_tuner_valid), etv);
      chk("pwr_read", int'(o_pwr_read), erd);
      chk("search_ack", int'(o_search_ack), esa);
      chk("lock_ack", int'(o_lock_ack), ela);
      if (esa != 0 || ela != 0) begin
         chk("rsp_pwr", int'(o_rsp_pwr), m_pwr);
         chk("rsp_err", int'(o_rsp_err), m_err);
      end
   endtask

   // Advance one clock: the model consumes the inputs driven for this edge, then outputs are checked.
   task automatic tick();
      if (!rst_n) mreset(); else mstep();
      @(negedge clk);
      compare();
   endtask

   task automatic drain();
      i_search_req = 0; i_lock_req = 0; i_pwr_valid = 0;
      for (int k = 0; k < 200 && m_busy; k++) tick();
      chk("drain_idle", int'(o_state), 0);
   endtask

   initial begin
      int cnt, n;
      int seq[4];
      bit dead;
      rst_n = 0; i_search_req = 0; i_lock_req = 0; i_pwr_valid = 0;
      i_search_code = '0; i_lock_code = '0; i_pwr = '0;
      mreset();
      tick(); tick(); tick();
      chk("rst_code", int'(o_tuner_code), 0);
      chk("rst_pwr", int'(o_rsp_pwr), 0);
      chk("rst_err", int'(o_rsp_err), 0);
      rst_n = 1;
      tick();

      // Search-only, detector answers on the first read cycle.
      i_search_req = 1; i_search_code = 8'h5A;
      tick();
      chk("t1_c1_code", int'(o_tuner_code), 'h5A);
      chk("t1_c1_valid", int'(o_tuner_valid), 1);
      chk("t1_c1_grant", int'(o_grant), 1);
      repeat (4) tick();
      chk("t1_c5_read", int'(o_pwr_read), 0);
      tick();
      chk("t1_c6_read", int'(o_pwr_read), 1);
      i_pwr_valid = 1; i_pwr = 8'h33;
      tick();
      chk("t1_c7_ack", int'(o_search_ack), 1);
      chk("t1_c7_pwr", int'(o_rsp_pwr), 'h33);
      chk("t1_c7_err", int'(o_rsp_err), 0);
      i_search_req = 0; i_pwr_valid = 0;
      tick();
      chk("t1_c8_state", int'(o_state), 0);
      chk("t1_c8_hold", int'(o_tuner_code), 'h5A);

      // Simultaneous requests: lock first, search served next.
      i_search_req = 1; i_search_code = 8'h10;
      i_lock_req = 1; i_lock_code = 8'h20;
      i_pwr_valid = 1; i_pwr = 8'h21;
      tick();
      chk("t2_grant0", int'(o_grant), 2);
      chk("t2_code0", int'(o_tuner_code), 'h20);
      repeat (6) tick();
      chk("t2_lock_ack", int'(o_lock_ack), 1);
      i_lock_req = 0;
      tick();
      chk("t2_init", int'(o_state), 0);
      tick();
      chk("t2_grant1", int'(o_grant), 1);
      chk("t2_code1", int'(o_tuner_code), 'h10);
      repeat (6) tick();
      chk("t2_search_ack", int'(o_search_ack), 1);
      drain();

      // Dead detector: read held TMO cycles then error ack.
      i_search_req = 1; i_search_code = 8'h66;
      repeat (6) tick();
      cnt = 0;
      for (int k = 0; k < 200; k++) begin
         if (o_search_ack) break;
         if (o_pwr_read) cnt++;
         tick();
      end
      chk("t3_read_cycles", cnt, 64);
      chk("t3_ack_seen", int'(o_search_ack), 1);
      chk("t3_err", int'(o_rsp_err), 1);
      chk("t3_pwr", int'(o_rsp_pwr), 0);
      i_search_req = 0;
      tick();
      chk("t3_init", int'(o_state), 0);

      // Code change after grant and a spurious sample during settle are ignored.
      i_search_req = 1; i_search_code = 8'h5A;
      tick(); tick();
      i_search_code = 8'hFF; i_pwr_valid = 1; i_pwr = 8'h77;
      tick();
      i_pwr_valid = 0;
      repeat (3) tick();
      chk("t4_read", int'(o_pwr_read), 1);
      i_pwr_valid = 1; i_pwr = 8'h44;
      tick();
      chk("t4_ack", int'(o_search_ack), 1);
      chk("t4_pwr", int'(o_rsp_pwr), 'h44);
      chk("t4_code", int'(o_tuner_code), 'h5A);
      chk("t4_err", int'(o_rsp_err), 0);
      drain();

      // Reset during SYNC: immediate clear, then the held request restarts.
      i_search_req = 1; i_search_code = 8'h3C;
      repeat (3) tick();
      rst_n = 0;
      #1;
      chk("t5_state", int'(o_state), 0);
      chk("t5_grant", int'(o_grant), 0);
      chk("t5_code", int'(o_tuner_code), 0);
      chk("t5_pwr", int'(o_rsp_pwr), 0);
      chk("t5_ack", int'(o_search_ack), 0);
      tick(); tick();
      rst_n = 1; i_pwr_valid = 1; i_pwr = 8'h12;
      tick();
      chk("t5_regrant", int'(o_grant), 1);
      chk("t5_recode", int'(o_tuner_code), 'h3C);
      repeat (6) tick();
      chk("t5_ack_after", int'(o_search_ack), 1);
      drain();

      // Both channels requesting continuously.
      n = 0;
      i_search_req = 1; i_lock_req = 1; i_pwr_valid = 1;
      for (int k = 0; k < 60 && n < 4; k++) begin
         tick();
         if (o_tuner_valid) begin seq[n] = int'(o_grant); n++; end
         if (e_sack) i_search_req = 0; else i_search_req = 1;
         if (e_lack) i_lock_req = 0; else i_lock_req = 1;
      end
      chk("t6_grants", n, 4);
`ifdef TUNER_ARB_RR_EN
      chk("t6_g0", seq[0], 2); chk("t6_g1", seq[1], 1);
      chk("t6_g2", seq[2], 2); chk("t6_g3", seq[3], 1);
`else
      chk("t6_g0", seq[0], 2); chk("t6_g1", seq[1], 2);
      chk("t6_g2", seq[2], 2); chk("t6_g3", seq[3], 2);
`endif
      drain();

      // Random traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         if (e_sack) i_search_req = 0;
         else if (!i_search_req && $urandom_range(3) == 0) begin
            i_search_req = 1; i_search_code = 8'($urandom_range(255));
         end else if ($urandom_range(15) == 0) i_search_code = 8'($urandom_range(255));
         if (e_lack) i_lock_req = 0;
         else if (!i_lock_req && $urandom_range(3) == 0) begin
            i_lock_req = 1; i_lock_code = 8'($urandom_range(255));
         end else if ($urandom_range(15) == 0) i_lock_code = 8'($urandom_range(255));
         dead = ((i / 400) % 3) == 2;
         i_pwr_valid = dead ? 1'b0 : ($urandom_range(2) == 0);
         i_pwr = 8'($urandom_range(255));
         rst_n = ($urandom_range(599) != 0);
         tick();
      end
      rst_n = 1;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
